// File: rtl/dt_ctrl.sv
// Dead-time insertion controller for one half-bridge leg.
// Turns a PWM command into complementary high/low-side gate enables with a
// programmable dead time. It also decides when the dead-time mux select may
// change, so a dead-time interval never sees a half-updated value.
module dt_ctrl #(
    parameter logic [3:0] DT_SEL_MAX = 4'd9,
    parameter logic [3:0] DT_SEL_RST = 4'd0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_pwm,
    input  logic       i_fault,
    input  logic       i_fault_clr,
    input  logic       i_dt_wr,
    input  logic [3:0] i_dt_sel,
    input  logic [4:0] i_dt,
    output logic [3:0] o_dt_sel,
    output logic       o_hs,
    output logic       o_ls,
    output logic       o_fault,
    output logic       o_cfg_err,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_DT_RISE = 3'd1,
        ST_HS_ON   = 3'd2,
        ST_DT_FALL = 3'd3,
        ST_LS_ON   = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    state_t     state_reg,   state_next;
    logic [4:0] cnt_reg,     cnt_next;
    logic [3:0] pend_reg,    pend_next;
    logic       pend_vld_reg, pend_vld_next;
    logic [3:0] dt_sel_reg,  dt_sel_next;
    logic       hs_reg,      hs_next;
    logic       ls_reg,      ls_next;
    logic       busy_reg,    busy_next;
    logic       fault_reg,   fault_next;
    logic       cfg_err_reg, cfg_err_next;

    logic [4:0] dt_load;
    logic       cur_stable;
    logic       nxt_stable;
    logic       wr_ok;

    // Counter preload: the exit edge is the one where the counter reads 0,
    // so loading i_dt-1 keeps both switches off for exactly i_dt cycles.
    // A zero count from the mux is clamped rather than wrapping to 31.
    assign dt_load = (i_dt == 5'd0) ? 5'd0 : (i_dt - 5'd1);

    // The select may only move when neither side of the edge is a dead-time
    // state, so a running interval and its entry both use one stable value.
    assign cur_stable = (state_reg  != ST_DT_RISE) && (state_reg  != ST_DT_FALL);
    assign nxt_stable = (state_next != ST_DT_RISE) && (state_next != ST_DT_FALL);
    assign wr_ok      = i_dt_wr && (i_dt_sel <= DT_SEL_MAX);

    // Next-state and dead-time counter; fault beats enable beats normal flow.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (i_fault) begin
            state_next = ST_FAULT;
            cnt_next   = 5'd0;
        end else if (state_reg == ST_FAULT) begin
            // A latched fault only leaves through an explicit clear.
            if (i_fault_clr) begin
                state_next = ST_OFF;
            end
            cnt_next = 5'd0;
        end else if (!i_en) begin
            state_next = ST_OFF;
            cnt_next   = 5'd0;
        end else begin
            unique case (state_reg)
                ST_OFF: begin
                    state_next = i_pwm ? ST_DT_RISE : ST_DT_FALL;
                    cnt_next   = dt_load;
                end
                ST_LS_ON: begin
                    if (i_pwm) begin
                        state_next = ST_DT_RISE;
                        cnt_next   = dt_load;
                    end
                end
                ST_HS_ON: begin
                    if (!i_pwm) begin
                        state_next = ST_DT_FALL;
                        cnt_next   = dt_load;
                    end
                end
                ST_DT_RISE: begin
                    // Dropping PWM mid-interval returns to the low side at
                    // once: the high side never turned on, so no shoot-through.
                    if (!i_pwm) begin
                        state_next = ST_LS_ON;
                        cnt_next   = 5'd0;
                    end else if (cnt_reg == 5'd0) begin
                        state_next = ST_HS_ON;
                    end else begin
                        cnt_next = cnt_reg - 5'd1;
                    end
                end
                ST_DT_FALL: begin
                    if (i_pwm) begin
                        state_next = ST_HS_ON;
                        cnt_next   = 5'd0;
                    end else if (cnt_reg == 5'd0) begin
                        state_next = ST_LS_ON;
                    end else begin
                        cnt_next = cnt_reg - 5'd1;
                    end
                end
                default: begin
                    state_next = ST_OFF;
                    cnt_next   = 5'd0;
                end
            endcase
        end
    end

    // Pending select, select apply, config error and output decode from the
    // next state so the gate enables change on the same edge as the state.
    always_comb begin
        pend_next     = pend_reg;
        pend_vld_next = pend_vld_reg;
        dt_sel_next   = dt_sel_reg;
        cfg_err_next  = 1'b0;

        // Apply uses the value pending before this edge; a write on the same
        // edge then becomes the new pending value.
        if (pend_vld_reg && cur_stable && nxt_stable) begin
            dt_sel_next   = pend_reg;
            pend_vld_next = 1'b0;
        end
        if (wr_ok) begin
            pend_next     = i_dt_sel;
            pend_vld_next = 1'b1;
        end
        if (i_dt_wr && !wr_ok) begin
            cfg_err_next = 1'b1;
        end

        hs_next    = (state_next == ST_HS_ON);
        ls_next    = (state_next == ST_LS_ON);
        busy_next  = (state_next == ST_DT_RISE) || (state_next == ST_DT_FALL);
        fault_next = (state_next == ST_FAULT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg    <= ST_OFF;
            cnt_reg      <= 5'd0;
            pend_reg     <= 4'd0;
            pend_vld_reg <= 1'b0;
            dt_sel_reg   <= DT_SEL_RST;
            hs_reg       <= 1'b0;
            ls_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            fault_reg    <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pend_reg     <= pend_next;
            pend_vld_reg <= pend_vld_next;
            dt_sel_reg   <= dt_sel_next;
            hs_reg       <= hs_next;
            ls_reg       <= ls_next;
            busy_reg     <= busy_next;
            fault_reg    <= fault_next;
            cfg_err_reg  <= cfg_err_next;
        end
    end

    assign o_dt_sel  = dt_sel_reg;
    assign o_hs      = hs_reg;
    assign o_ls      = ls_reg;
    assign o_busy    = busy_reg;
    assign o_fault   = fault_reg;
    assign o_cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_dt_ctrl.sv
// Testbench for dt_ctrl: vector table plus hand sequences, scoreboarded.
// Each driven cycle pushes its expected outputs; a checker pops and compares
// them shortly after the following rising edge.
module tb_dt_ctrl;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       pwm;
        logic       flt_in;
        logic       clr;
        logic       wr;
        logic [3:0] sel;
        logic       hs;
        logic       ls;
        logic       busy;
        logic       flt;
        logic       err;
        logic [3:0] dsel;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pwm;
    logic       fault_in;
    logic       fault_clr;
    logic       dt_wr;
    logic [3:0] dt_sel_in;
    logic [4:0] dt_val;
    logic [3:0] dt_sel;
    logic       hs;
    logic       ls;
    logic       fault;
    logic       cfg_err;
    logic       busy;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t exp_q[$];
    vec_t e;

    // Dead-time mux model: select 0..9 -> 2,4,..,20 cycles.
    assign dt_val = {dt_sel, 1'b0} + 5'd2;

    dt_ctrl #(.DT_SEL_MAX(4'd9), .DT_SEL_RST(4'd0)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_pwm       (pwm),
        .i_fault     (fault_in),
        .i_fault_clr (fault_clr),
        .i_dt_wr     (dt_wr),
        .i_dt_sel    (dt_sel_in),
        .i_dt        (dt_val),
        .o_dt_sel    (dt_sel),
        .o_hs        (hs),
        .o_ls        (ls),
        .o_fault     (fault),
        .o_cfg_err   (cfg_err),
        .o_busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t v(input logic rn, input logic en_i, input logic pwm_i,
                               input logic fi, input logic cl, input logic wr_i,
                               input logic [3:0] sel_i, input logic ehs, input logic els,
                               input logic ebusy, input logic eflt, input logic eerr,
                               input logic [3:0] edsel, input string nm);
        vec_t t;
        t.rst_n = rn;   t.en = en_i;  t.pwm = pwm_i; t.flt_in = fi;
        t.clr = cl;     t.wr = wr_i;  t.sel = sel_i;
        t.hs = ehs;     t.ls = els;   t.busy = ebusy; t.flt = eflt;
        t.err = eerr;   t.dsel = edsel; t.name = nm;
        return t;
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue its expectation.
    task automatic step(input vec_t t);
        @(negedge clk);
        rst_n     = t.rst_n;
        en        = t.en;
        pwm       = t.pwm;
        fault_in  = t.flt_in;
        fault_clr = t.clr;
        dt_wr     = t.wr;
        dt_sel_in = t.sel;
        exp_q.push_back(t);
    endtask

    task automatic rep(input int n, input vec_t t);
        for (int k = 0; k < n; k++) step(t);
    endtask

    // Scoreboard checker: compare outputs settled after each rising edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (hs !== e.hs || ls !== e.ls || busy !== e.busy || fault !== e.flt ||
                cfg_err !== e.err || dt_sel !== e.dsel || (hs && ls)) begin
                n_miss++;
                $display("FAIL %s @%0t: got hs=%b ls=%b busy=%b fault=%b err=%b sel=%0d, want hs=%b ls=%b busy=%b fault=%b err=%b sel=%0d",
                         e.name, $time, hs, ls, busy, fault, cfg_err, dt_sel,
                         e.hs, e.ls, e.busy, e.flt, e.err, e.dsel);
            end else begin
                $display("ok   %s @%0t: hs=%b ls=%b busy=%b fault=%b err=%b sel=%0d",
                         e.name, $time, hs, ls, busy, fault, cfg_err, dt_sel);
            end
        end
    end

    vec_t tbl[13];

    initial begin
        rst_n = 1'b0; en = 1'b0; pwm = 1'b0; fault_in = 1'b0;
        fault_clr = 1'b0; dt_wr = 1'b0; dt_sel_in = 4'd0;

        // Reset, then 2-cycle dead times on both PWM edges (select 0).
        tbl[0]  = v(0,0,0,0,0,0,0, 0,0,0,0,0,0, "reset0");
        tbl[1]  = v(0,1,0,0,0,0,0, 0,0,0,0,0,0, "reset1");
        tbl[2]  = v(1,1,0,0,0,0,0, 0,0,1,0,0,0, "off_to_dtfall");
        tbl[3]  = v(1,1,0,0,0,0,0, 0,0,1,0,0,0, "dtfall_cnt");
        tbl[4]  = v(1,1,0,0,0,0,0, 0,1,0,0,0,0, "ls_on");
        tbl[5]  = v(1,1,0,0,0,0,0, 0,1,0,0,0,0, "ls_hold");
        tbl[6]  = v(1,1,1,0,0,0,0, 0,0,1,0,0,0, "ls_fall");
        tbl[7]  = v(1,1,1,0,0,0,0, 0,0,1,0,0,0, "dtrise_cnt");
        tbl[8]  = v(1,1,1,0,0,0,0, 1,0,0,0,0,0, "hs_on");
        tbl[9]  = v(1,1,1,0,0,0,0, 1,0,0,0,0,0, "hs_hold");
        tbl[10] = v(1,1,0,0,0,0,0, 0,0,1,0,0,0, "hs_fall");
        tbl[11] = v(1,1,0,0,0,0,0, 0,0,1,0,0,0, "dtfall_cnt2");
        tbl[12] = v(1,1,0,0,0,0,0, 0,1,0,0,0,0, "ls_on2");
        for (int i = 0; i < 13; i++) step(tbl[i]);

        // Select 3 written in LS_ON, applied on the following edge; 8-cycle dead times.
        step(v(1,1,0,0,0,1,3, 0,1,0,0,0,0, "wr3"));
        step(v(1,1,0,0,0,0,0, 0,1,0,0,0,3, "apply3"));
        rep(8, v(1,1,1,0,0,0,0, 0,0,1,0,0,3, "dt8_rise"));
        step(v(1,1,1,0,0,0,0, 1,0,0,0,0,3, "hs_after8"));
        rep(8, v(1,1,0,0,0,0,0, 0,0,1,0,0,3, "dt8_fall"));
        step(v(1,1,0,0,0,0,0, 0,1,0,0,0,3, "ls_after8"));

        // Illegal select, then a legal write coinciding with a PWM edge.
        step(v(1,1,0,0,0,1,12, 0,1,0,0,1,3, "bad_sel"));
        step(v(1,1,0,0,0,0,0,  0,1,0,0,0,3, "err_pulse_end"));
        step(v(1,1,1,0,0,1,9,  0,0,1,0,0,3, "wr9_edge"));
        rep(7, v(1,1,1,0,0,0,0, 0,0,1,0,0,3, "dt_old_sel"));
        step(v(1,1,1,0,0,0,0, 1,0,0,0,0,3, "hs_old_sel"));
        step(v(1,1,1,0,0,0,0, 1,0,0,0,0,9, "apply9"));
        rep(20, v(1,1,0,0,0,0,0, 0,0,1,0,0,9, "dt20_fall"));
        step(v(1,1,0,0,0,0,0, 0,1,0,0,0,9, "ls_after20"));

        // Short PWM pulse aborts the rising dead time back to LS_ON.
        rep(5, v(1,1,1,0,0,0,0, 0,0,1,0,0,9, "abort_rise"));
        step(v(1,1,0,0,0,0,0, 0,1,0,0,0,9, "abort_ls"));

        // Fault during HS_ON, ignored clear, real clear, recovery.
        rep(20, v(1,1,1,0,0,0,0, 0,0,1,0,0,9, "dt20_rise"));
        step(v(1,1,1,0,0,0,0, 1,0,0,0,0,9, "hs_after20"));
        step(v(1,1,1,1,0,0,0, 0,0,0,1,0,9, "fault_in"));
        step(v(1,1,1,1,1,0,0, 0,0,0,1,0,9, "clr_ignored"));
        step(v(1,1,1,0,0,0,0, 0,0,0,1,0,9, "fault_held"));
        step(v(1,1,1,0,1,0,0, 0,0,0,0,0,9, "fault_clr"));
        rep(20, v(1,1,1,0,0,0,0, 0,0,1,0,0,9, "dt20_recover"));
        step(v(1,1,1,0,0,0,0, 1,0,0,0,0,9, "hs_return"));

        // Falling abort, enable drop, reset mid-rise with a pending write.
        step(v(1,1,0,0,0,0,0, 0,0,1,0,0,9, "fall_start"));
        step(v(1,1,1,0,0,0,0, 1,0,0,0,0,9, "fall_abort"));
        step(v(1,0,1,0,0,0,0, 0,0,0,0,0,9, "en_off"));
        step(v(1,1,1,0,0,1,4, 0,0,1,0,0,9, "wr4_rise"));
        step(v(1,1,1,0,0,0,0, 0,0,1,0,0,9, "rise_mid"));
        step(v(0,1,1,0,0,0,0, 0,0,0,0,0,0, "rst_mid_dt"));
        rep(2, v(1,1,1,0,0,0,0, 0,0,1,0,0,0, "dt2_post_rst"));
        step(v(1,1,1,0,0,0,0, 1,0,0,0,0,0, "hs_post_rst"));
        step(v(1,1,1,0,0,0,0, 1,0,0,0,0,0, "pend_lost"));

        // Let the checker drain; anything left unchecked is a miscompare.
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dt_ctrl.md
Name: dt_ctrl

Overview:
- Dead-time insertion controller for one half-bridge leg; turns a single PWM command into complementary high-side/low-side gate enables.
- Drives the 4-bit select of the dead-time value mux and takes back its 5-bit dead-time count (mux map: sel 0..9 -> 2,4,..,20 cycles).
- Owns when the mux select may change, so a dead-time interval never uses a half-updated value.
- Sits between the PWM/modulator stage and the gate-driver outputs.

Parameters:
- DT_SEL_MAX, 9, highest legal dead-time select; writes above this are rejected.
- DT_SEL_RST, 0, select value loaded at reset (2-cycle dead time).

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_en  in  1  leg enable; low forces both switches off
- i_pwm  in  1  PWM command, synchronous to i_clk; 1 = high side on, 0 = low side on
- i_fault  in  1  fault input; level-sensitive
- i_fault_clr  in  1  one-cycle strobe that clears a latched fault
- i_dt_wr  in  1  one-cycle strobe that writes a new dead-time select
- i_dt_sel  in  4  dead-time select value written on i_dt_wr
- i_dt  in  5  dead-time cycle count returned by the mux for o_dt_sel (combinational)
- o_dt_sel  out  4  registered select driven to the dead-time mux
- o_hs  out  1  high-side gate enable, registered
- o_ls  out  1  low-side gate enable, registered
- o_fault  out  1  sticky fault flag
- o_cfg_err  out  1  one-cycle pulse when a write is rejected
- o_busy  out  1  high while in a dead-time state

Behaviour:
- Reset (i_rst_n=0 at an edge): state OFF; o_hs=0, o_ls=0, o_fault=0, o_cfg_err=0, o_busy=0; o_dt_sel=DT_SEL_RST; pending register cleared, with its valid bit at 0.
- Priority at every edge: reset > fault > !i_en > normal FSM.
- Outputs are decoded from the next state and registered with it, so there is zero extra latency beyond one edge.
  - HS_ON: o_hs=1.
  - LS_ON: o_ls=1.
  - All other states: both 0.
  - o_hs and o_ls are never 1 together.
- States: OFF, DT_RISE, HS_ON, DT_FALL, LS_ON, FAULT.
- Dead-time counter: loaded with i_dt-1 on entry to DT_RISE or DT_FALL, using the i_dt for the current o_dt_sel. It decrements each cycle in the DT state; the exit transition happens at the edge where the counter is 0. Both outputs are therefore low for exactly i_dt cycles.
- Transitions:
  - OFF & i_en: i_pwm=1 -> DT_RISE, else -> DT_FALL.
  - LS_ON & i_pwm=1 -> DT_RISE.
  - HS_ON & i_pwm=0 -> DT_FALL.
  - DT_RISE & cnt=0 & i_pwm=1 -> HS_ON.
  - DT_RISE & i_pwm=0 (abort) -> LS_ON immediately; the high side was never on, so this is safe.
  - DT_FALL & cnt=0 & i_pwm=0 -> LS_ON.
  - DT_FALL & i_pwm=1 (abort) -> HS_ON immediately.
  - Any state & i_en=0 -> OFF.
  - Any state & i_fault=1 -> FAULT; o_fault is set to 1.
  - FAULT & i_fault_clr & !i_fault -> OFF; o_fault is cleared to 0. A clear strobe while i_fault=1 is ignored.
- Select writes:
  - i_dt_wr with i_dt_sel <= DT_SEL_MAX loads the pending register and sets its valid bit. A later write overwrites the pending value.
  - i_dt_wr with i_dt_sel > DT_SEL_MAX: o_cfg_err pulses for 1 cycle; pending is unchanged.
  - Pending is applied (o_dt_sel <= pending, valid cleared) only at an edge where the current state and next state are both in {OFF, LS_ON, HS_ON, FAULT}. It is never applied during or on entry to a DT state.
  - A write in the same cycle as a PWM edge: the new dead time uses the old select. The new value applies after that dead time completes.
  - A write and an apply in the same cycle: the apply uses the old pending value, and the new write becomes pending.
- o_busy = 1 iff the state is DT_RISE or DT_FALL.
- Reset mid-dead-time: the next edge gives OFF with the counter cleared. The pending write is lost, and o_dt_sel returns to DT_SEL_RST.

Test Plan:
- Reset, i_en=1, i_pwm=0, mux default sel 0 -> o_ls rises 2 cycles after OFF exit. Then i_pwm=1 -> o_ls falls at the next edge, o_hs rises exactly 2 edges later, and o_busy=1 for those 2 cycles.
- Write i_dt_sel=3 while in LS_ON -> o_dt_sel=3 one edge later. The next rising PWM edge gives both outputs low for 8 cycles; the falling edge gives both low for 8 cycles.
- Write i_dt_sel=12 -> o_cfg_err high for 1 cycle; o_dt_sel unchanged. Write 9 in the same cycle as a PWM edge -> that dead time uses the old value; the next dead time is 20 cycles.
- With sel=9, pulse i_pwm high for 5 cycles from LS_ON -> abort back to LS_ON with o_hs never asserted. Check overlap o_hs&o_ls = 0 on every cycle of every test.
- Assert i_fault during HS_ON -> both outputs 0 and o_fault=1 at the next edge. i_fault_clr while i_fault=1 is ignored. Drop i_fault, then clear -> OFF. With i_en=1 and i_pwm=1, o_hs returns after one full dead time.
- Assert i_rst_n=0 mid-DT_RISE with a pending write -> the next edge gives OFF, both outputs 0, o_dt_sel=0, and the pending write is discarded.
